// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit slice.
//   - MMU width codes driven onto mmu_data_width
//   - RV32 load/store funct3 encodings (stores reuse the LB/LH/LW codes)
//   - LSU FSM state type
package load_store_unit_pkg;

  localparam logic [1:0] MMU_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MMU_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_decode.sv
// lsu_decode: combinational funct3/address decode for the load/store unit.
// Ports:
//   store       in   1  1 = store, 0 = load
//   funct3      in   3  RV32 funct3
//   addr_lo     in   2  low two address bits
//   width       out  2  MMU_WIDTH_* code
//   signed_read out  1  sign-extend load result (LB/LH only)
//   misaligned  out  1  half on odd address or word not 4-byte aligned
//   illegal     out  1  funct3 not a legal load/store encoding
module lsu_decode
  import load_store_unit_pkg::*;
(
  input  logic       store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [1:0] width,
  output logic       signed_read,
  output logic       misaligned,
  output logic       illegal
);

  always_comb begin
    width       = MMU_WIDTH_BYTE;
    signed_read = 1'b0;
    illegal     = 1'b0;
    case (funct3)
      F3_LB: begin
        width       = MMU_WIDTH_BYTE;
        signed_read = ~store;
      end
      F3_LH: begin
        width       = MMU_WIDTH_HALF;
        signed_read = ~store;
      end
      F3_LW: width = MMU_WIDTH_WORD;
      F3_LBU: begin
        width   = MMU_WIDTH_BYTE;
        illegal = store;
      end
      F3_LHU: begin
        width   = MMU_WIDTH_HALF;
        illegal = store;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Alignment only matters for legal encodings; illegal ones error anyway.
  always_comb begin
    misaligned = 1'b0;
    if (!illegal) begin
      misaligned = ((width == MMU_WIDTH_HALF) && addr_lo[0]) ||
                   ((width == MMU_WIDTH_WORD) && (addr_lo != 2'b00));
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage front end for the mmu.
// Accepts one load/store request at a time, decodes funct3 into mmu width/sign
// controls, rejects misaligned/illegal accesses, holds the mmu enables until
// mmu_ready (or a timeout) and returns one registered response per request.
// Ports:
//   clk, reset (async active-low)
//   req_valid/req_ready handshake; req_store, req_funct3, req_addr, req_wdata
//   resp_valid (1-cycle pulse), resp_rdata, resp_error
//   mmu_write_enable, mmu_read_enable, mmu_signed_read, mmu_data_width,
//   mmu_address, mmu_data_in (registered, to mmu); mmu_data_out, mmu_ready (from mmu)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mmu_write_enable,
  output logic        mmu_read_enable,
  output logic        mmu_signed_read,
  output logic [1:0]  mmu_data_width,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_data_in,
  input  logic [31:0] mmu_data_out,
  input  logic        mmu_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;
  logic          timeout;
  logic          store_q;

  logic [1:0]    dec_width;
  logic          dec_signed;
  logic          dec_misaligned;
  logic          dec_illegal;

  lsu_decode u_decode (
    .store       (req_store),
    .funct3      (req_funct3),
    .addr_lo     (req_addr[1:0]),
    .width       (dec_width),
    .signed_read (dec_signed),
    .misaligned  (dec_misaligned),
    .illegal     (dec_illegal)
  );

  // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle, so WAIT never
  // lasts longer than TIMEOUT_CYCLES cycles.
  always_comb begin
    wait_cnt_next = wait_cnt + 1'b1;
    timeout       = (wait_cnt_next == CW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= LSU_IDLE;
      wait_cnt         <= '0;
      store_q          <= 1'b0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_error       <= 1'b0;
      mmu_write_enable <= 1'b0;
      mmu_read_enable  <= 1'b0;
      mmu_signed_read  <= 1'b0;
      mmu_data_width   <= MMU_WIDTH_BYTE;
      mmu_address      <= '0;
      mmu_data_in      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            store_q         <= req_store;
            mmu_address     <= req_addr;
            mmu_data_in     <= req_wdata;
            mmu_data_width  <= dec_width;
            mmu_signed_read <= dec_signed;
            req_ready       <= 1'b0;
            if (dec_illegal || dec_misaligned) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state      <= LSU_RESP;
            end else begin
              mmu_read_enable  <= ~req_store;
              mmu_write_enable <= req_store;
              state            <= LSU_ISSUE;
            end
          end
        end
        // mmu_ready may still be high from the previous access; not sampled here.
        LSU_ISSUE: begin
          wait_cnt <= '0;
          state    <= LSU_WAIT;
        end
        LSU_WAIT: begin
          wait_cnt <= wait_cnt_next;
          if (mmu_ready) begin
            mmu_read_enable  <= 1'b0;
            mmu_write_enable <= 1'b0;
            resp_valid       <= 1'b1;
            resp_error       <= 1'b0;
            resp_rdata       <= store_q ? '0 : mmu_data_out;
            state            <= LSU_RESP;
          end else if (timeout) begin
            mmu_read_enable  <= 1'b0;
            mmu_write_enable <= 1'b0;
            resp_valid       <= 1'b1;
            resp_error       <= 1'b1;
            resp_rdata       <= '0;
            state            <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          wait_cnt  <= '0;
          req_ready <= 1'b1;
          state     <= LSU_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural mmu stub with per-request
// latency, byte-array reference model, scoreboard queue checked by a
// monitor on every resp_valid pulse.
module tb_load_store_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mmu_write_enable;
  logic        mmu_read_enable;
  logic        mmu_signed_read;
  logic [1:0]  mmu_data_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;
  logic        mmu_ready;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mmu_write_enable (mmu_write_enable),
    .mmu_read_enable  (mmu_read_enable),
    .mmu_signed_read  (mmu_signed_read),
    .mmu_data_width   (mmu_data_width),
    .mmu_address      (mmu_address),
    .mmu_data_in      (mmu_data_in),
    .mmu_data_out     (mmu_data_out),
    .mmu_ready        (mmu_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] ref_mem[256];
  logic [7:0] stub_mem[256];
  int         next_lat = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // mmu stub: ready arrives lat cycles after the issue cycle (99 = never);
  // a random stale ready may show up during the issue cycle.
  initial begin : mmu_stub
    bit         prev_en = 1'b0;
    bit         en;
    int         cnt = 0;
    int         cur_lat = 1;
    int         nb;
    logic [7:0] a8;
    logic [31:0] v;
    mmu_ready    = 1'b0;
    mmu_data_out = '0;
    forever begin
      @(posedge clk); #1;
      en = mmu_read_enable || mmu_write_enable;
      if (en) begin
        if (!prev_en) begin
          cnt     = 0;
          cur_lat = next_lat;
        end else cnt++;
        if (cnt == 0) begin
          mmu_ready    = 1'($urandom % 2);
          mmu_data_out = $urandom;
        end else if (cnt == cur_lat) begin
          mmu_ready = 1'b1;
          nb = (mmu_data_width == 2'b00) ? 1 : (mmu_data_width == 2'b01) ? 2 : 4;
          a8 = mmu_address[7:0];
          if (mmu_write_enable) begin
            for (int i = 0; i < nb; i++) stub_mem[a8 + 8'(i)] = mmu_data_in[8*i +: 8];
            mmu_data_out = $urandom;
          end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = stub_mem[a8 + 8'(i)];
            if (mmu_signed_read && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (mmu_signed_read && nb == 2) v = {{16{v[15]}}, v[15:0]};
            mmu_data_out = v;
          end
        end else begin
          mmu_ready    = 1'b0;
          mmu_data_out = $urandom;
        end
      end else begin
        mmu_ready    = 1'($urandom % 2);
        mmu_data_out = $urandom;
      end
      prev_en = en;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (reset && resp_valid) begin
        if (expq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", 32'(resp_error), 32'(e.err));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Must be entered at #1 after an edge with req_ready high.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    exp_t        e;
    int          size;
    bit          bad;
    bit          saw_en;
    int          guard;
    logic [31:0] v;
    logic [7:0]  idx;
    if (st) bad = (f3 > 3'd2);
    else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!bad && (int'(a[1:0]) % size) != 0) bad = 1'b1;
    e.rdata = '0;
    e.err   = 1'b1;
    if (bad) e.cyc = cyc + 1;
    else if (lat > int'(TO)) e.cyc = cyc + 2 + int'(TO);
    else begin
      e.err = 1'b0;
      e.cyc = cyc + 2 + lat;
      if (st) begin
        for (int i = 0; i < size; i++) begin
          idx = a[7:0] + 8'(i);
          ref_mem[idx] = wd[8*i +: 8];
        end
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) begin
          idx = a[7:0] + 8'(i);
          v[8*i +: 8] = ref_mem[idx];
        end
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
      end
    end
    expq.push_back(e);
    next_lat   = lat;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    saw_en = 1'b0;
    guard  = 0;
    // Keep junk requests on the bus while busy; they must be ignored.
    while (!req_ready && guard < 200) begin
      saw_en     = saw_en | mmu_read_enable | mmu_write_enable;
      req_valid  = 1'b1;
      req_store  = 1'($urandom % 2);
      req_funct3 = 3'($urandom % 8);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b0;
    chk("return_to_idle", 32'(req_ready), 32'd1);
    if (bad) chk("no_enable_on_error", 32'(saw_en), 32'd0);
  endtask

  initial begin : stimulus
    int r;
    int lat;
    int guard;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]  = 8'($urandom);
      stub_mem[i] = ref_mem[i];
    end
    // Word 0 holds 0x00200293 in both the stub memory and the model.
    ref_mem[0] = 8'h93; ref_mem[1] = 8'h02; ref_mem[2] = 8'h20; ref_mem[3] = 8'h00;
    for (int i = 0; i < 4; i++) stub_mem[i] = ref_mem[i];

    #13;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_enables", {30'd0, mmu_read_enable, mmu_write_enable}, 32'd0);
    chk("rst_mmu_address", mmu_address, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_req(1'b1, 3'b010, 32'h0000_0080, 32'hBABA_BABA, 3);
    do_req(1'b0, 3'b010, 32'h0000_0080, 32'h0, 2);
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, 4);
    do_req(1'b0, 3'b000, 32'h0000_0000, 32'h0, 1);
    do_req(1'b0, 3'b100, 32'h0000_0000, 32'h0, 2);
    do_req(1'b0, 3'b101, 32'h0000_0000, 32'h0, 5);
    do_req(1'b0, 3'b001, 32'h0000_0000, 32'h0, 1);
    do_req(1'b0, 3'b010, 32'h0000_0082, 32'h0, 1);
    do_req(1'b0, 3'b001, 32'h0000_0081, 32'h0, 1);
    do_req(1'b0, 3'b011, 32'h0000_0080, 32'h0, 1);
    do_req(1'b1, 3'b100, 32'h0000_0080, 32'h1234_5678, 1);
    do_req(1'b0, 3'b010, 32'h0000_0080, 32'h0, 99);
    do_req(1'b1, 3'b001, 32'h0000_0090, 32'hDEAD_BEEF, 99);
    do_req(1'b0, 3'b010, 32'h0000_0090, 32'h0, TO);
    do_req(1'b1, 3'b000, 32'h0000_0091, 32'h0000_00A5, TO);
    do_req(1'b0, 3'b001, 32'h0000_0090, 32'h0, 3);

    // Reset during WAIT: enables drop at once, no response for the lost load.
    next_lat   = 99;
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("en_before_reset", 32'(mmu_read_enable), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("reset_read_enable", 32'(mmu_read_enable), 32'd0);
    chk("reset_write_enable", 32'(mmu_write_enable), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'h0, 2);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom % 3) begin
        @(posedge clk); #1;
      end
      r = int'($urandom % 10);
      if (r == 0) lat = 99;
      else if (r == 1) lat = int'(TO);
      else lat = 1 + int'($urandom % 6);
      do_req(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, lat);
    end

    guard = 0;
    while (expq.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
